ball_motion_ctrl: RTL

Frame-synchronous motion controller for the on-screen ball in the VGA datapath. Latches the USB keycode exported by the Nios II SoC once per frame, turns it into a per-axis velocity, and steps the ball position with wall bounce. Sits between the SoC's `keycode_export` / `vga_port_vs` and the pixel colour mapper, which consumes `ball_x` / `ball_y` / `ball_size`. Also drives the SoC-side hex display with the current position.

---
 rtl/ball_motion_ctrl_if.sv | 21 ++
 rtl/ball_motion_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ball_motion_ctrl_if.sv
// Frame/keycode inputs and ball position outputs of ball_motion_ctrl.
// The SoC/VGA side drives through master; the controller attaches as slave.
interface ball_motion_ctrl_if;
  logic        vga_port_vs;
  logic [7:0]  keycode_export;
  logic [9:0]  ball_x;
  logic [9:0]  ball_y;
  logic [9:0]  ball_size;
  logic [15:0] hex_digits_export;
  logic        frame_done;

  modport master (
    output vga_port_vs, keycode_export,
    input  ball_x, ball_y, ball_size, hex_digits_export, frame_done
  );

  modport slave (
    input  vga_port_vs, keycode_export,
    output ball_x, ball_y, ball_size, hex_digits_export, frame_done
  );
endinterface

// File: rtl/ball_motion_ctrl.sv
// Frame-synchronous ball motion: keycode -> velocity, wall bounce, one step per VS rise.
// Define BALL_WRAP_EN to replace the wall bounce with wrap-around between the bounds.
module ball_motion_ctrl #(
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 479,
  parameter int X_CENTER  = 320,
  parameter int Y_CENTER  = 240,
  parameter int STEP      = 1,
  parameter int BALL_SIZE = 4
) (
  input logic              clk_clk,
  input logic              reset_reset_n,
  ball_motion_ctrl_if.slave bus
);

  // state    | meaning
  // S_WAIT   | idle, waiting for a VS rising edge
  // S_CMD    | decode latched keycode into velocity
  // S_MOVE   | apply wall rule, compute next position
  // S_COMMIT | publish position, pulse frame_done
  typedef enum logic [1:0] {S_WAIT, S_CMD, S_MOVE, S_COMMIT} state_t;

  localparam logic signed [4:0]  L_STEP_P = 5'(STEP);
  localparam logic signed [4:0]  L_STEP_N = -L_STEP_P;
  localparam logic signed [10:0] L_XMIN   = 11'(X_MIN);
  localparam logic signed [10:0] L_XMAX   = 11'(X_MAX);
  localparam logic signed [10:0] L_YMIN   = 11'(Y_MIN);
  localparam logic signed [10:0] L_YMAX   = 11'(Y_MAX);
  localparam logic signed [10:0] L_BS     = 11'(BALL_SIZE);
  localparam logic [9:0]         L_XC     = 10'(X_CENTER);
  localparam logic [9:0]         L_YC     = 10'(Y_CENTER);

  state_t             r_state, w_state_nxt;
  logic               r_vs_q;
  logic [7:0]         r_key_lat;
  logic signed [4:0]  r_mx, r_my;
  logic signed [10:0] r_nx, r_ny;
  logic [9:0]         r_x, r_y;
  logic [15:0]        r_hex;
  logic               r_frame_done;

  logic               w_edge;
  logic signed [4:0]  w_mx_cmd, w_my_cmd, w_mx_mv, w_my_mv;
  logic signed [10:0] w_x_s, w_y_s, w_nx, w_ny;
  logic               w_unused;

  assign w_edge = bus.vga_port_vs & ~r_vs_q;
  assign w_x_s  = signed'({1'b0, r_x});
  assign w_y_s  = signed'({1'b0, r_y});

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) r_state <= S_WAIT;
    else                r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT:   if (w_edge) w_state_nxt = S_CMD;
      S_CMD:    w_state_nxt = S_MOVE;
      S_MOVE:   w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_WAIT;
      default:  w_state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    w_mx_cmd = r_mx;
    w_my_cmd = r_my;
    case (r_key_lat)
      8'h1A: begin w_mx_cmd = '0;       w_my_cmd = L_STEP_N; end
      8'h16: begin w_mx_cmd = '0;       w_my_cmd = L_STEP_P; end
      8'h04: begin w_mx_cmd = L_STEP_N; w_my_cmd = '0;       end
      8'h07: begin w_mx_cmd = L_STEP_P; w_my_cmd = '0;       end
      8'h2C: begin w_mx_cmd = '0;       w_my_cmd = '0;       end
      default: ;
    endcase
  end

  always_comb begin
    w_mx_mv = r_mx;
    w_my_mv = r_my;
`ifdef BALL_WRAP_EN
    w_nx = w_x_s + 11'(w_mx_mv);
    w_ny = w_y_s + 11'(w_my_mv);
    if (w_nx > L_XMAX)      w_nx = L_XMIN;
    else if (w_nx < L_XMIN) w_nx = L_XMAX;
    if (w_ny > L_YMAX)      w_ny = L_YMIN;
    else if (w_ny < L_YMIN) w_ny = L_YMAX;
`else
    // Wall contact reverses the axis regardless of the keyed direction.
    if (r_mx > 5'sd0 && w_x_s + L_BS >= L_XMAX)      w_mx_mv = L_STEP_N;
    else if (r_mx < 5'sd0 && w_x_s - L_BS <= L_XMIN) w_mx_mv = L_STEP_P;
    if (r_my > 5'sd0 && w_y_s + L_BS >= L_YMAX)      w_my_mv = L_STEP_N;
    else if (r_my < 5'sd0 && w_y_s - L_BS <= L_YMIN) w_my_mv = L_STEP_P;
    w_nx = w_x_s + 11'(w_mx_mv);
    w_ny = w_y_s + 11'(w_my_mv);
`endif
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_vs_q       <= 1'b1;
      r_key_lat    <= '0;
      r_mx         <= '0;
      r_my         <= '0;
      r_nx         <= 11'(X_CENTER);
      r_ny         <= 11'(Y_CENTER);
      r_x          <= L_XC;
      r_y          <= L_YC;
      r_hex        <= {L_XC[7:0], L_YC[7:0]};
      r_frame_done <= 1'b0;
    end else begin
      r_vs_q       <= bus.vga_port_vs;
      r_frame_done <= 1'b0;
      case (r_state)
        S_WAIT: if (w_edge) r_key_lat <= bus.keycode_export;
        S_CMD: begin
          r_mx <= w_mx_cmd;
          r_my <= w_my_cmd;
        end
        S_MOVE: begin
          r_mx <= w_mx_mv;
          r_my <= w_my_mv;
          r_nx <= w_nx;
          r_ny <= w_ny;
        end
        S_COMMIT: begin
          r_x          <= r_nx[9:0];
          r_y          <= r_ny[9:0];
          r_hex        <= {r_nx[7:0], r_ny[7:0]};
          r_frame_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sign bits are dropped by the 10-bit truncation at commit.
  assign w_unused = r_nx[10] ^ r_ny[10];

  assign bus.ball_x            = r_x;
  assign bus.ball_y            = r_y;
  assign bus.ball_size         = 10'(BALL_SIZE);
  assign bus.hex_digits_export = r_hex;
  assign bus.frame_done        = r_frame_done;

endmodule
